// File: rtl/mps_analog_intl.sv
// -----------------------------------------------------------------------------
// mps_analog_intl
//
// Per-channel analog interlock. Each incoming signed sample is compared
// against that channel's programmable upper/lower limits. Consecutive
// violating samples are counted per channel. When the count reaches the
// debounce threshold and the channel is not masked, the channel's interlock
// flag latches until it is explicitly cleared.
//
// Pipeline:
//   stage 1 - register sample, channel and the channel's current limits
//   stage 2 - compare, update debounce counter and interlock latch
// A sample strobed in cycle N shows its trip on o_analog_intl in cycle N+2.
//
// Build option:
//   INTL_FIRST_OUT_EN - when defined, o_first_ch/o_first_valid capture the
//                       first channel to latch after a clear. When undefined,
//                       both outputs are tied to zero.
//
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous, active-low reset
//   i_sample_valid  sample strobe
//   i_sample_ch     channel index of the sample
//   i_sample_data   signed sample value
//   i_cfg_we        limit write strobe
//   i_cfg_addr      {channel[4:0], sel}; sel 1 = upper limit, 0 = lower limit
//   i_cfg_data      signed limit value
//   i_deb_cnt       consecutive violating samples needed to trip (0 acts as 1)
//   i_intl_mask     per-channel mask; 1 = channel may not latch
//   i_intl_clr      clear pulse for latches, counters and first-out state
//   o_analog_intl   latched per-channel interlock flags
//   o_intl_any      OR of o_analog_intl
//   o_first_ch      first-tripped channel
//   o_first_valid   o_first_ch holds a captured channel
// -----------------------------------------------------------------------------
module mps_analog_intl #(
  parameter int CH_NUM     = 18,
  parameter int DATA_WIDTH = 32,
  parameter int DEB_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sample_valid,
  input  logic [4:0]            i_sample_ch,
  input  logic [DATA_WIDTH-1:0] i_sample_data,
  input  logic                  i_cfg_we,
  input  logic [5:0]            i_cfg_addr,
  input  logic [DATA_WIDTH-1:0] i_cfg_data,
  input  logic [DEB_WIDTH-1:0]  i_deb_cnt,
  input  logic [CH_NUM-1:0]     i_intl_mask,
  input  logic                  i_intl_clr,
  output logic [CH_NUM-1:0]     o_analog_intl,
  output logic                  o_intl_any,
  output logic [4:0]            o_first_ch,
  output logic                  o_first_valid
);

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic        [DEB_WIDTH-1:0]  cnt_t;

  localparam data_t LIM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam data_t LIM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Limit storage
  // ---------------------------------------------------------------------------
  data_t upper_q [CH_NUM];
  data_t upper_d [CH_NUM];
  data_t lower_q [CH_NUM];
  data_t lower_d [CH_NUM];

  logic [4:0] cfg_ch;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    upper_d = upper_q;
    lower_d = lower_q;
    cfg_ch  = i_cfg_addr[5:1];
    if (i_cfg_we && (int'(cfg_ch) < CH_NUM)) begin
      if (i_cfg_addr[0]) upper_d[cfg_ch] = data_t'(i_cfg_data);
      else               lower_d[cfg_ch] = data_t'(i_cfg_data);
    end
  end

  // Limits open wide at reset so that nothing trips before configuration.
  // NOTE: this small register file is deliberately reset; its reset value is
  // functional, unlike a RAM whose contents would be don't-care.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      upper_q <= '{default: LIM_MAX};
      lower_q <= '{default: LIM_MIN};
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      upper_q <= upper_d;
      lower_q <= lower_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture sample and the addressed channel's limits
  // ---------------------------------------------------------------------------
  logic       s1_valid_q, s1_valid_d;
  logic [4:0] s1_ch_q,    s1_ch_d;
  data_t      s1_data_q,  s1_data_d;
  data_t      s1_upper_q, s1_upper_d;
  data_t      s1_lower_q, s1_lower_d;

  always_comb begin
    // Out-of-range channels never enter stage 2, so they cannot touch state.
    s1_valid_d = i_sample_valid && (int'(i_sample_ch) < CH_NUM);
    s1_ch_d    = i_sample_ch;
    s1_data_d  = data_t'(i_sample_data);
    s1_upper_d = LIM_MAX;
    s1_lower_d = LIM_MIN;
    if (s1_valid_d) begin
      s1_upper_d = upper_q[i_sample_ch];
      s1_lower_d = lower_q[i_sample_ch];
    end
  end

  // Only the valid bit is reset: it alone discards an in-flight sample.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) s1_valid_q <= 1'b0;
    else        s1_valid_q <= s1_valid_d;
  end

  always_ff @(posedge i_clk) begin
    s1_ch_q    <= s1_ch_d;
    s1_data_q  <= s1_data_d;
    s1_upper_q <= s1_upper_d;
    s1_lower_q <= s1_lower_d;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: compare, debounce, latch
  // ---------------------------------------------------------------------------
  cnt_t              cnt_q [CH_NUM];
  cnt_t              cnt_d [CH_NUM];
  logic [CH_NUM-1:0] latch_q, latch_d;
  logic [4:0]        first_ch_q, first_ch_d;
  logic              first_valid_q, first_valid_d;

  logic violation;
  cnt_t cnt_cur;
  cnt_t cnt_new;
  cnt_t threshold;
  logic trip;

  always_comb begin
    cnt_d         = cnt_q;
    latch_d       = latch_q;
    first_ch_d    = first_ch_q;
    first_valid_d = first_valid_q;

    violation = (s1_data_q > s1_upper_q) || (s1_data_q < s1_lower_q);
    cnt_cur   = cnt_q[s1_ch_q];
    if (!violation)          cnt_new = '0;
    else if (cnt_cur == '1)  cnt_new = cnt_cur;
    else                     cnt_new = cnt_cur + cnt_t'(1);

    threshold = (i_deb_cnt == '0) ? cnt_t'(1) : i_deb_cnt;
    // Counting continues while masked; only the latch is gated by the mask.
    trip = s1_valid_q && (cnt_new >= threshold) && !i_intl_mask[s1_ch_q];

    if (s1_valid_q) begin
      cnt_d[s1_ch_q] = cnt_new;
      if (trip) latch_d[s1_ch_q] = 1'b1;
    end

    // First-out only tracks a fresh latch, never a re-trip of a set flag.
    if (trip && !latch_q[s1_ch_q] && !first_valid_q) begin
      first_ch_d    = s1_ch_q;
      first_valid_d = 1'b1;
    end

    // Clear has priority over a trip arriving in the same cycle.
    if (i_intl_clr) begin
      cnt_d         = '{default: '0};
      latch_d       = '0;
      first_ch_d    = '0;
      first_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q   <= '{default: '0};
      latch_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
    end
  end

`ifdef INTL_FIRST_OUT_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
    end else begin
      first_ch_q    <= first_ch_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign o_first_ch    = first_ch_q;
  assign o_first_valid = first_valid_q;
`else
  assign first_ch_q    = '0;
  assign first_valid_q = 1'b0;
  assign o_first_ch    = '0;
  assign o_first_valid = 1'b0;
`endif

  assign o_analog_intl = latch_q;
  assign o_intl_any    = |latch_q;

endmodule

// File: tb/tb_mps_analog_intl.sv
// -----------------------------------------------------------------------------
// tb_mps_analog_intl
//
// Directed bench for mps_analog_intl: reset state, a table of limit-compare
// vectors, then hand-written sequences for debounce, counter reset, clear
// priority, masking, first-out capture and reset during an in-flight sample.
// -----------------------------------------------------------------------------
module tb_mps_analog_intl;

  localparam int CH_NUM = 18;
  localparam int DW     = 32;
  localparam int DEBW   = 16;

  localparam logic [DW-1:0] MAXV = 32'h7FFF_FFFF;
  localparam logic [DW-1:0] MINV = 32'h8000_0000;

  logic              clk;
  logic              rst_n;
  logic              sample_valid;
  logic [4:0]        sample_ch;
  logic [DW-1:0]     sample_data;
  logic              cfg_we;
  logic [5:0]        cfg_addr;
  logic [DW-1:0]     cfg_data;
  logic [DEBW-1:0]   deb_cnt;
  logic [CH_NUM-1:0] intl_mask;
  logic              intl_clr;
  logic [CH_NUM-1:0] analog_intl;
  logic              intl_any;
  logic [4:0]        first_ch;
  logic              first_valid;

  int checks = 0;
  int errors = 0;

`ifdef INTL_FIRST_OUT_EN
  localparam bit FO_EN = 1'b1;
`else
  localparam bit FO_EN = 1'b0;
`endif

  mps_analog_intl #(
    .CH_NUM    (CH_NUM),
    .DATA_WIDTH(DW),
    .DEB_WIDTH (DEBW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_sample_valid(sample_valid),
    .i_sample_ch   (sample_ch),
    .i_sample_data (sample_data),
    .i_cfg_we      (cfg_we),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_data    (cfg_data),
    .i_deb_cnt     (deb_cnt),
    .i_intl_mask   (intl_mask),
    .i_intl_clr    (intl_clr),
    .o_analog_intl (analog_intl),
    .o_intl_any    (intl_any),
    .o_first_ch    (first_ch),
    .o_first_valid (first_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a stuck run.
  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input bit sel, input logic [DW-1:0] val);
    cfg_we   = 1'b1;
    cfg_addr = {5'(ch), sel};
    cfg_data = val;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic sample(input int ch, input logic [DW-1:0] val);
    sample_valid = 1'b1;
    sample_ch    = 5'(ch);
    sample_data  = val;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic clear();
    intl_clr = 1'b1;
    tick();
    intl_clr = 1'b0;
  endtask

  function automatic logic [31:0] bit_of(input int ch);
    return 32'(1) << ch;
  endfunction

  typedef struct {
    int            ch;
    logic [DW-1:0] upper;
    logic [DW-1:0] lower;
    logic [DW-1:0] data;
    bit            trip;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Limit-compare vectors, debounce of 1 (deb_cnt = 0 acts as 1).
    vecs[0] = '{0,  32'd100,       -32'sd100, 32'd100,      1'b0}; // equal upper
    vecs[1] = '{0,  32'd100,       -32'sd100, 32'd101,      1'b1};
    vecs[2] = '{1,  32'd100,       -32'sd100, -32'sd100,    1'b0}; // equal lower
    vecs[3] = '{1,  32'd100,       -32'sd100, -32'sd101,    1'b1};
    vecs[4] = '{17, 32'd0,         32'd0,     32'd0,        1'b0}; // last channel
    vecs[5] = '{17, 32'd0,         32'd0,     32'hFFFF_FFFF, 1'b1}; // -1 < 0
    vecs[6] = '{4,  MAXV,          MINV,      MAXV,         1'b0};
    vecs[7] = '{10, -32'sd5,       -32'sd10,  32'd5,        1'b1}; // signed upper
    vecs[8] = '{11, 32'd10,        -32'sd10,  MINV,         1'b1}; // signed lower
    vecs[9] = '{18, 32'd0,         32'd0,     32'd1000,     1'b0}; // out of range

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_ch    = '0;
    sample_data  = '0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_data     = '0;
    deb_cnt      = '0;
    intl_mask    = '0;
    intl_clr     = 1'b0;

    #12;
    check("rst_intl",        32'(analog_intl), 32'd0);
    check("rst_any",         32'(intl_any),    32'd0);
    check("rst_first_ch",    32'(first_ch),    32'd0);
    check("rst_first_valid", 32'(first_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Unconfigured limits accept the full range.
    sample(0, MAXV);
    sample(0, MINV);
    tick();
    check("unconfigured_no_trip", 32'(analog_intl), 32'd0);

    // Compare table; each limit is written the cycle before the sample.
    for (int i = 0; i < 10; i++) begin
      clear();
      deb_cnt = '0;
      cfg_write(vecs[i].ch, 1'b1, vecs[i].upper);
      cfg_write(vecs[i].ch, 1'b0, vecs[i].lower);
      sample(vecs[i].ch, vecs[i].data);
      tick();
      check($sformatf("vec%0d_intl", i), 32'(analog_intl),
            vecs[i].trip ? bit_of(vecs[i].ch) : 32'd0);
      check($sformatf("vec%0d_any", i), 32'(intl_any), 32'(vecs[i].trip));
    end

    // ch3, debounce 3: two violations hold off, three trip at N+2.
    clear();
    deb_cnt = 16'd3;
    cfg_write(3, 1'b1, 32'd1000);
    sample(3, 32'd1001);
    sample(3, 32'd1001);
    tick();
    tick();
    check("deb3_two_samples", 32'(analog_intl), 32'd0);
    clear();
    sample(3, 32'd1001);
    sample(3, 32'd1001);
    sample(3, 32'd1001);
    check("deb3_latency_n1", 32'(analog_intl), 32'd0);
    tick();
    check("deb3_latency_n2", 32'(analog_intl), bit_of(3));

    // ch5, debounce 2: a good sample in between restarts the count.
    clear();
    deb_cnt = 16'd2;
    cfg_write(5, 1'b0, -32'sd500);
    sample(5, -32'sd501);
    sample(5, 32'd0);
    sample(5, -32'sd501);
    tick();
    tick();
    check("ch5_counter_reset", 32'(analog_intl), 32'd0);
    sample(5, -32'sd501);
    tick();
    check("ch5_trip", 32'(analog_intl), bit_of(5));

    // ch7: clear arrives with the trip and wins; counter is cleared too.
    clear();
    deb_cnt = 16'd1;
    cfg_write(7, 1'b1, 32'd1000);
    sample(7, 32'd1001);
    intl_clr = 1'b1;
    tick();
    intl_clr = 1'b0;
    check("clr_wins_intl", 32'(analog_intl), 32'd0);
    check("clr_wins_any",  32'(intl_any),    32'd0);
    deb_cnt = 16'd2;
    sample(7, 32'd1001);
    tick();
    check("clr_counter_zero", 32'(analog_intl), 32'd0);
    sample(7, 32'd1001);
    tick();
    check("clr_then_trip", 32'(analog_intl), bit_of(7));

    // ch2 masked: counts but cannot latch; unmask, one more violation trips.
    clear();
    deb_cnt   = 16'd2;
    intl_mask = 18'(bit_of(2));
    cfg_write(2, 1'b1, 32'd1000);
    for (int i = 0; i < 4; i++) sample(2, 32'd1001);
    tick();
    tick();
    check("masked_no_flag", 32'(analog_intl), 32'd0);
    intl_mask = '0;
    sample(2, 32'd1001);
    tick();
    check("unmask_trip", 32'(analog_intl), bit_of(2));
    intl_mask = 18'(bit_of(2));
    sample(2, 32'd0);
    tick();
    tick();
    check("latched_holds", 32'(analog_intl), bit_of(2));
    intl_mask = '0;

    // First-out: ch9 then ch1; out-of-range sample changes nothing.
    clear();
    deb_cnt = 16'd1;
    cfg_write(9, 1'b1, 32'd1000);
    cfg_write(1, 1'b1, 32'd1000);
    sample(9, 32'd1001);
    sample(1, 32'd1001);
    tick();
    check("fo_intl",  32'(analog_intl), bit_of(9) | bit_of(1));
    check("fo_ch",    32'(first_ch),    FO_EN ? 32'd9 : 32'd0);
    check("fo_valid", 32'(first_valid), 32'(FO_EN));
    sample(20, 32'd1001);
    tick();
    tick();
    check("fo_ch20_intl",  32'(analog_intl), bit_of(9) | bit_of(1));
    check("fo_ch20_ch",    32'(first_ch),    FO_EN ? 32'd9 : 32'd0);
    check("fo_ch20_valid", 32'(first_valid), 32'(FO_EN));
    clear();
    check("fo_clr_intl",  32'(analog_intl), 32'd0);
    check("fo_clr_ch",    32'(first_ch),    32'd0);
    check("fo_clr_valid", 32'(first_valid), 32'd0);

    // Reset while a tripping sample sits in stage 1 discards it.
    deb_cnt = 16'd1;
    cfg_write(6, 1'b1, 32'd1000);
    sample(6, 32'd1001);
    rst_n = 1'b0;
    #2;
    check("midrst_intl", 32'(analog_intl), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("midrst_discard", 32'(analog_intl), 32'd0);
    sample(6, 32'd1001);
    tick();
    check("midrst_limits_reset", 32'(analog_intl), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mps_analog_intl.md
MPS_ANALOG_INTL -- requirements
Module: mps_analog_intl

Interface
REQ-001 SHALL have parameter CH_NUM, default 18, number of monitored analog channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, signed sample width.
REQ-003 SHALL have parameter DEB_WIDTH, default 16, debounce counter width.
REQ-004 SHALL have the following ports, clock and reset first:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_sample_valid  in  1  sample strobe.
- i_sample_ch  in  5  channel index of sample.
- i_sample_data  in  DATA_WIDTH  signed sample value.
- i_cfg_we  in  1  limit write strobe.
- i_cfg_addr  in  6  {channel[4:0], sel}; sel 1=upper limit, 0=lower limit.
- i_cfg_data  in  DATA_WIDTH  signed limit value.
- i_deb_cnt  in  DEB_WIDTH  consecutive violating samples required to trip.
- i_intl_mask  in  CH_NUM  1 = channel may not latch.
- i_intl_clr  in  1  interlock clear pulse.
- o_analog_intl  out  CH_NUM  latched per-channel interlock flags; feeds the system interlock input.
- o_intl_any  out  1  OR of o_analog_intl.
- o_first_ch  out  5  first-tripped channel.
- o_first_valid  out  1  o_first_ch holds a captured channel.

Function
REQ-005 SHALL store one upper and one lower signed limit per channel, written on i_cfg_we; writes to channel >= CH_NUM ignored.
REQ-006 SHALL use a 2-stage pipeline: stage 1 registers sample, channel, and that channel's limits; stage 2 compares and updates counter/latch.
REQ-007 SHALL flag a violation when data > upper limit or data < lower limit (signed compare); equal to a limit is not a violation.
REQ-008 SHALL ignore samples with i_sample_ch >= CH_NUM (no counter or latch change).
REQ-009 SHALL, per channel, increment its counter (saturating at all-ones) on each violating sample and zero it on each non-violating sample of that channel; other channels unaffected.
REQ-010 SHALL set o_analog_intl[ch] when the updated count >= max(i_deb_cnt,1) and i_intl_mask[ch]=0; i_deb_cnt=0 behaves as 1.
REQ-011 SHALL make the latch visible 2 cycles after the tripping i_sample_valid (sample cycle N -> flag high at N+2).
REQ-012 SHALL keep a latched flag set until i_intl_clr, regardless of later samples or mask changes.
REQ-013 SHALL keep counting for masked channels; on unmask, the next violating sample with count >= threshold latches.
REQ-014 SHALL apply a limit write in cycle N to samples presented in cycle N+1 or later.
REQ-015 SHALL, on i_intl_clr, zero all latches, counters and first-out state in the next cycle; clear wins over a simultaneous trip.
REQ-016 SHALL drive o_intl_any combinationally as |o_analog_intl.

Reset
REQ-017 SHALL, on i_rst low, asynchronously zero o_analog_intl, counters, pipeline valid, o_first_ch, o_first_valid.
REQ-018 SHALL reset upper limits to maximum positive and lower limits to minimum negative, so no channel trips before configuration.
REQ-019 SHALL discard any in-flight pipeline sample when reset asserts mid-operation.

Configuration
REQ-020 SHALL compile first-out capture only when macro INTL_FIRST_OUT_EN is defined: o_first_ch/o_first_valid capture the channel of the first latch set while o_first_valid=0, held until clear; only one channel can trip per cycle.
REQ-021 SHALL, without INTL_FIRST_OUT_EN, tie o_first_ch and o_first_valid to 0.

Verification
REQ-022 SHALL cover: ch3 upper=1000, deb=3, three samples 1001 -> o_analog_intl[3] rises 2 cycles after third sample; after two -> stays 0.
REQ-023 SHALL cover: ch5 lower=-500, deb=2, samples -501, 0, -501 -> no trip (counter reset); then -501 again -> trip.
REQ-024 SHALL cover: ch7 tripped and i_intl_clr in same cycle as ch7 trip -> flag 0 after clear; counter 0.
REQ-025 SHALL cover: mask[2]=1, ch2 violates 4x at deb=2 -> no flag; unmask, one more violation -> flag set.
REQ-026 SHALL cover (INTL_FIRST_OUT_EN): ch9 trips then ch1 -> o_first_ch=9, o_first_valid=1; clear -> both 0; sample on ch 20 -> no change.
